// File: rtl/l1_mem_ctrl_pkg.sv
// Shared constants, clear-FSM state encoding and parameter legality helpers
// for the L1 memory controller.
package l1_mem_ctrl_pkg;

   localparam logic        ENABLE    = 1'b1;
   localparam logic        DISABLE   = 1'b0;
   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
   localparam int          BE_W      = 4;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } clr_state_e;

   // A fetch line must be a power of two between 1 and 8 words.
   function automatic bit fetch_words_legal(input int fw);
      return (fw >= 1) && (fw <= 8) && ((fw & (fw - 1)) == 0);
   endfunction

endpackage

// File: rtl/l1_clear_fsm.sv
// Post-reset zero-fill sequencer: walks every word index once, one per cycle,
// then holds READY until the next reset.
module l1_clear_fsm
   import l1_mem_ctrl_pkg::*;
#(
   parameter int DEPTH = 4096,
   parameter int IDX_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   output logic             clr_we,
   output logic [IDX_W-1:0] clr_addr,
   output logic             ready_o
);

   clr_state_e       state_reg, state_next;
   logic [IDX_W-1:0] clr_ptr_reg, clr_ptr_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= ST_CLEAR;
         clr_ptr_reg <= '0;
      end else begin
         state_reg   <= state_next;
         clr_ptr_reg <= clr_ptr_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      clr_ptr_next = clr_ptr_reg;
      clr_we       = DISABLE;
      ready_o      = DISABLE;
      case (state_reg)
         ST_CLEAR: begin
            clr_we = ENABLE;
            if (clr_ptr_reg == IDX_W'(DEPTH - 1)) begin
               state_next = ST_READY;
            end else begin
               clr_ptr_next = clr_ptr_reg + IDX_W'(1);
            end
         end
         ST_READY: begin
            ready_o = ENABLE;
         end
         default: begin
            state_next = ST_CLEAR;
         end
      endcase
   end

   assign clr_addr = clr_ptr_reg;

endmodule

// File: rtl/l1_mem_ctrl.sv
// L1 memory controller: banked word array with a line-wide fetch port and a
// byte-enable load/store port. Define L1_FWD_EN to forward same-word store data to loads.
module l1_mem_ctrl
   import l1_mem_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DEPTH       = 4096,
   parameter int FETCH_WORDS = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      jump_flag_i,
   input  logic                      hold_flag_i,
   input  logic                      inst_re_i,
   input  logic [ADDR_W-1:0]         inst_raddr_i,
   output logic                      inst_re_o,
   output logic [FETCH_WORDS*32-1:0] inst_rdata_o,
   output logic [ADDR_W-1:0]         inst_raddr_o,
   input  logic                      data_we_i,
   input  logic [3:0]                data_be_i,
   input  logic [ADDR_W-1:0]         data_waddr_i,
   input  logic [31:0]               data_wdata_i,
   input  logic                      data_re_i,
   input  logic [ADDR_W-1:0]         data_raddr_i,
   output logic                      data_re_o,
   output logic [31:0]               data_rdata_o,
   output logic                      ready_o
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int FW_LOG = $clog2(FETCH_WORDS);
   localparam int ROW_W  = IDX_W - FW_LOG;
   localparam int ROWS   = DEPTH / FETCH_WORDS;
   localparam int LINE_W = FETCH_WORDS * 32;
   localparam logic [IDX_W-1:0] BANK_MASK = IDX_W'(FETCH_WORDS - 1);

   generate
      if (!fetch_words_legal(FETCH_WORDS) || (DEPTH <= FETCH_WORDS) ||
          ((DEPTH & (DEPTH - 1)) != 0) || (ADDR_W < IDX_W + 2)) begin : g_param_check
         $error("l1_mem_ctrl: illegal DEPTH/FETCH_WORDS/ADDR_W combination");
      end
   endgenerate

   // Word i lives in bank i % FETCH_WORDS at row i / FETCH_WORDS, so an
   // aligned fetch line is one row read across all banks.
   function automatic logic [ROW_W-1:0] row_of(input logic [IDX_W-1:0] idx);
      logic [IDX_W-1:0] shifted;
      shifted = idx >> FW_LOG;
      return shifted[ROW_W-1:0];
   endfunction

   function automatic logic bank_hit(input logic [IDX_W-1:0] idx, input int bank);
      return (idx & BANK_MASK) == IDX_W'(bank);
   endfunction

   logic             clr_we;
   logic [IDX_W-1:0] clr_addr;

   l1_clear_fsm #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_clear_fsm (
      .clk      (clk),
      .rst      (rst),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .ready_o  (ready_o)
   );

   logic [IDX_W-1:0] f_idx, st_idx, ld_idx;
   logic [ROW_W-1:0] f_row, ld_row, wr_row;
   logic [IDX_W-1:0] wr_idx;
   logic [31:0]      wr_data;
   logic [BE_W-1:0]  wr_be;

   assign f_idx  = inst_raddr_i[IDX_W+1:2];
   assign st_idx = data_waddr_i[IDX_W+1:2];
   assign ld_idx = data_raddr_i[IDX_W+1:2];
   assign f_row  = row_of(f_idx);
   assign ld_row = row_of(ld_idx);

   logic unused_addr_bits;
   assign unused_addr_bits = ^{inst_raddr_i[ADDR_W-1:IDX_W+2], inst_raddr_i[1:0],
                               data_waddr_i[ADDR_W-1:IDX_W+2], data_waddr_i[1:0],
                               data_raddr_i[ADDR_W-1:IDX_W+2], data_raddr_i[1:0]};

   // Single write port shared by the clear sequencer and the store path.
   always_comb begin
      wr_idx  = st_idx;
      wr_data = data_wdata_i;
      wr_be   = '0;
      if (clr_we) begin
         wr_idx  = clr_addr;
         wr_data = ZERO_WORD;
         wr_be   = '1;
      end else if (ready_o && data_we_i) begin
         wr_be = data_be_i;
      end
   end

   assign wr_row = row_of(wr_idx);

   logic [LINE_W-1:0] fetch_line;
   logic [31:0]       bank_ld_word [FETCH_WORDS];
   logic [FETCH_WORDS-1:0] ld_bank_hit;

   genvar gi;
   generate
      for (gi = 0; gi < FETCH_WORDS; gi++) begin : g_bank
         logic [31:0] mem [ROWS];

         always_ff @(posedge clk) begin
            if (bank_hit(wr_idx, gi)) begin
               for (int n = 0; n < BE_W; n++) begin
                  if (wr_be[n]) begin
                     mem[wr_row][8*n +: 8] <= wr_data[8*n +: 8];
                  end
               end
            end
         end

         assign fetch_line[32*gi +: 32] = mem[f_row];
         assign bank_ld_word[gi]        = mem[ld_row];
         assign ld_bank_hit[gi]         = bank_hit(ld_idx, gi);
      end
   endgenerate

   logic [31:0] ld_old_word;
   logic [31:0] ld_word;

   always_comb begin
      ld_old_word = ZERO_WORD;
      for (int b = 0; b < FETCH_WORDS; b++) begin
         if (ld_bank_hit[b]) begin
            ld_old_word = bank_ld_word[b];
         end
      end
   end

`ifdef L1_FWD_EN
   logic [31:0] fwd_word;

   always_comb begin
      fwd_word = ld_old_word;
      for (int n = 0; n < BE_W; n++) begin
         if (data_be_i[n]) begin
            fwd_word[8*n +: 8] = data_wdata_i[8*n +: 8];
         end
      end
   end

   assign ld_word = (ready_o && data_we_i && (st_idx == ld_idx)) ? fwd_word : ld_old_word;
`else
   assign ld_word = ld_old_word;
`endif

   logic              inst_re_reg;
   logic [LINE_W-1:0] inst_rdata_reg;
   logic [ADDR_W-1:0] inst_raddr_reg;
   logic              data_re_reg;
   logic [31:0]       data_rdata_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inst_re_reg    <= DISABLE;
         inst_rdata_reg <= '0;
         inst_raddr_reg <= '0;
         data_re_reg    <= DISABLE;
         data_rdata_reg <= ZERO_WORD;
      end else if (!ready_o) begin
         inst_re_reg    <= DISABLE;
         inst_rdata_reg <= '0;
         inst_raddr_reg <= '0;
         data_re_reg    <= DISABLE;
         data_rdata_reg <= ZERO_WORD;
      end else begin
         // Flush beats stall; a stalled request is dropped, not queued.
         if (jump_flag_i) begin
            inst_re_reg    <= DISABLE;
            inst_rdata_reg <= '0;
            inst_raddr_reg <= '0;
         end else if (!hold_flag_i) begin
            if (inst_re_i) begin
               inst_re_reg    <= ENABLE;
               inst_rdata_reg <= fetch_line;
               inst_raddr_reg <= inst_raddr_i;
            end else begin
               inst_re_reg    <= DISABLE;
               inst_rdata_reg <= '0;
               inst_raddr_reg <= '0;
            end
         end
         data_re_reg    <= data_re_i;
         data_rdata_reg <= data_re_i ? ld_word : ZERO_WORD;
      end
   end

   assign inst_re_o    = inst_re_reg;
   assign inst_rdata_o = inst_rdata_reg;
   assign inst_raddr_o = inst_raddr_reg;
   assign data_re_o    = data_re_reg;
   assign data_rdata_o = data_rdata_reg;

endmodule
